// File: rtl/counting_pkg.sv
// Shared symbol encoding for the 2-bit sequence link and the transmitter state encoding.
package counting_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_A    = 2'b01;
    localparam logic [1:0] SYM_B    = 2'b10;
    localparam logic [1:0] SYM_C    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYM1 = 3'd1,
        ST_SYM2 = 3'd2,
        ST_SYM3 = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    function automatic logic [1:0] state_symbol(input state_t s);
        case (s)
            ST_SYM1: return SYM_A;
            ST_SYM2: return SYM_B;
            ST_SYM3: return SYM_C;
            default: return SYM_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/counting_gap_timer.sv
// Loadable 8-bit down-counter timing the idle symbols between frames.
module counting_gap_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic       zero
);

    logic [7:0] value_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= 8'd0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (enable && (value_reg != 8'd0)) begin
            value_reg <= value_reg - 8'd1;
        end
    end

    assign zero = (value_reg == 8'd0);

endmodule

// File: rtl/counting_gen.sv
// Burst transmitter: emits N frames of 01,10,11 with GAP idle symbols between frames.
module counting_gen
    import counting_pkg::*;
#(
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [1:0]       num,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         HAS_GAP  = (GAP > 0);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] frames_next;
    logic [CNT_W-1:0] frames_inc;
    logic             done_next;
    logic             gap_load;
    logic             gap_enable;
    logic             gap_zero;

    counting_gap_timer u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .enable     (gap_enable),
        .zero       (gap_zero)
    );

    assign frames_inc = frames_sent + CNT_W'(1);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        frames_next = frames_sent;
        done_next   = 1'b0;
        gap_load    = 1'b0;
        gap_enable  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // abort is ignored here, so start always wins when both are high
                if (start) begin
                    frames_next = '0;
                    if (count != '0) begin
                        count_next = count;
                        state_next = ST_SYM1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_SYM1: state_next = abort ? ST_IDLE : ST_SYM2;
            ST_SYM2: state_next = abort ? ST_IDLE : ST_SYM3;
            ST_SYM3: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    frames_next = frames_inc;
                    if (frames_inc == count_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (HAS_GAP) begin
                        state_next = ST_GAP;
                        gap_load   = 1'b1;
                    end else begin
                        state_next = ST_SYM1;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (gap_zero) begin
                    state_next = ST_SYM1;
                end else begin
                    gap_enable = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            frames_sent <= '0;
            num         <= SYM_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            frames_sent <= frames_next;
            num         <= state_symbol(state_next);
            busy        <= (state_next != ST_IDLE);
            done        <= done_next;
        end
    end

endmodule

// File: doc/counting_gen.md
Name: counting_gen

Overview:
- Transmit side of the 2-bit symbol sequence link; drives a `num` bus that the sequence detector samples every clock.
- On request, emits N frames. Each frame is the symbol run 01 → 10 → 11, with a programmable number of idle 00 symbols between frames.
- Reports busy, frame progress and completion.
- Used as the stimulus source for the detector and as the link transmitter at system level.

Parameters:
- GAP, 2, number of 00 idle cycles inserted between consecutive frames (0..255); 0 means frames are back-to-back.
- CNT_W, 8, width of the frame-count request and the progress counter.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse, sampled on posedge; ignored while busy.
- count  input  CNT_W  number of frames to send; sampled only when start is accepted.
- abort  input  1  synchronous cancel of an in-progress burst.
- num  output  2  registered symbol bus to the link.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse at normal burst completion.
- frames_sent  output  CNT_W  frames fully emitted in the current or most recent burst.

Behaviour:
- Reset (async, immediate, mid-burst included):
  - state=IDLE, num=00, busy=0, done=0, frames_sent=0.
  - Gap counter and latched count are cleared.
  - No partial frame completes after reset.
- All outputs are registered and decoded from state. num has no combinational path from any input.
- States and symbols: IDLE (num=00), SYM1 (01), SYM2 (10), SYM3 (11), GAP (00).
- IDLE:
  - start=1 and count!=0 at edge t: latch count, clear frames_sent, go to SYM1 at edge t.
  - Result: num=01 and busy=1 during cycle t..t+1. Latency from start sample to first symbol is one edge.
  - start=1 and count==0: stay in IDLE; done=1 for the cycle after edge t; busy stays 0; frames_sent=0.
- SYM1 → SYM2 → SYM3: one cycle each, unconditionally, unless abort is asserted.
- Leaving SYM3 at edge e, frames_sent increments at edge e. Next state:
  - frames_sent+1 == latched count: go to IDLE; busy=0 and done=1 for exactly one cycle after edge e.
  - else GAP>0: go to GAP with the gap counter loaded to GAP-1. num=00 for exactly GAP cycles, then SYM1.
  - else (GAP==0): go to SYM1 directly. Pattern is 01,10,11,01,...
- abort=1 while busy (any non-IDLE state):
  - Next edge goes to IDLE, num=00, busy=0, done stays 0.
  - frames_sent holds its value; a frame interrupted mid-run is not counted.
  - Abort in the same cycle as the final SYM3: abort wins, done=0, frames_sent not incremented.
  - abort in IDLE is ignored.
  - start and abort together in IDLE: start is accepted.
- start while busy: ignored; latched count unchanged.
- Width and wrap rules:
  - count up to 2^CNT_W-1 is supported; frames_sent never wraps within a burst.
  - Gap counter width is 8 bits, fixed.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package counting_pkg holds:
  - symbol constants SYM_IDLE=2'b00, SYM_A=2'b01, SYM_B=2'b10, SYM_C=2'b11, so transmitter and detector share the encoding;
  - the 3-bit state encoding for counting_gen.
- One sub-module, counting_gap_timer: loadable 8-bit down-counter with load, enable and a zero flag; reset asynchronously to 0.
- Everything else stays in counting_gen.

Test Plan:
- Reset then start=1,count=1,GAP=2 → num 01,10,11 on three consecutive cycles; then 00; busy high exactly 3 cycles; done=1 one cycle right after; frames_sent=1.
- count=3,GAP=2 → num 01,10,11,00,00,01,10,11,00,00,01,10,11,00; done once after the third 11; frames_sent steps 1,2,3.
- GAP=0,count=2 → 01,10,11,01,10,11 back-to-back; no 00 between frames; done after the sixth symbol.
- count=4, abort during the second frame's SYM2 → next cycle num=00, busy=0, done never asserted, frames_sent=1. A following start,count=1 restarts cleanly from 01 with frames_sent reset to 0.
- start with count=0 → no non-zero symbol; busy stays 0; done=1 for one cycle. A second start pulse during a count=5 burst is ignored (exactly 5 frames emitted).
- Assert reset asynchronously mid-SYM3 of frame 2 → num=00, busy=0, frames_sent=0 before the next clock edge; no done pulse afterwards.
